board_io_ctrl: RTL and testbench
================================

Name: board_io_ctrl

Overview:
Parametrised board-level I/O conditioner between raw pushbuttons/LEDs and the SoC GPIO bank. Synchronises and debounces NUM_BTN buttons, and produces level, edge pulses and sticky event flags for firmware. Drives NUM_LED LEDs in per-channel modes: direct, PWM brightness, blink or forced off. Successor to the current toplevel's hard-wired gpio-bit-to-LED assignment; instantiated in toplevel beside MuraxCustom.

Parameters:
NUM_BTN, 2, number of button channels
NUM_LED, 2, number of LED channels
BTN_ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed
DEBOUNCE_CYCLES, 120000, cycles a new level must hold before acceptance (>=2)
PWM_BITS, 8, PWM duty/counter width
BLINK_LOG2, 22, blink period = 2^BLINK_LOG2 cycles

Ports:
io_mainClk  in  1  system clock
io_asyncResetN  in  1  asynchronous, active-low reset
btn_raw  in  NUM_BTN  asynchronous pad inputs
btn_level  out  NUM_BTN  debounced level, 1 = pressed
btn_press  out  NUM_BTN  1-cycle pulse on debounced press
btn_release  out  NUM_BTN  1-cycle pulse on debounced release
btn_event  out  NUM_BTN  sticky press flag
btn_event_clr  in  NUM_BTN  per-channel clear of btn_event
led_write  in  NUM_LED  GPIO-driven LED request bits
led_mode  in  2*NUM_LED  per-LED mode, channel i at [2i+1:2i]
led_duty  in  PWM_BITS*NUM_LED  per-LED duty, channel i at [PWM_BITS*(i+1)-1:PWM_BITS*i]
led_out  out  NUM_LED  LED pad drive, 1 = on

Behaviour:
- All flops clear asynchronously on io_asyncResetN=0 and release synchronously on the io_mainClk edge; no other reset.
- Reset values: btn_level, btn_press, btn_release, btn_event, led_out = 0. Sync flops reset to the "not pressed" raw level, so reset release produces no spurious press.
- Sync: 2-FF synchroniser per button; normalised to pressed=1 after the second flop.
- Debounce, per channel: counter of width clog2(DEBOUNCE_CYCLES).
  - synced == btn_level: counter cleared.
  - synced != btn_level: counter increments. When the counter equals DEBOUNCE_CYCLES-1 and the level still differs, btn_level toggles next cycle and the counter clears.
  - Any bounce back to btn_level before acceptance clears the counter.
- Latency: a clean raw press is reflected on btn_level 2+DEBOUNCE_CYCLES cycles after the first sampling edge.
- btn_press/btn_release: registered; asserted in the same cycle btn_level changes, for exactly 1 cycle.
- btn_event: set by btn_press, cleared by btn_event_clr. Press and clr in the same cycle: set wins.
- LED modes: 00 DIRECT, 01 PWM, 10 BLINK, 11 OFF.
  - DIRECT: led_out = led_write.
  - PWM: led_out = led_write & (pwm_cnt < duty). duty=0 gives always off; duty=2^PWM_BITS-1 gives on 255/256 of the time for PWM_BITS=8.
  - BLINK: led_out = led_write & blink_cnt MSB.
  - OFF: led_out = 0.
- Shared counters: one free-running PWM_BITS pwm_cnt and one BLINK_LOG2 blink_cnt. Both reset to 0 and wrap silently at all-ones.
- led_out is registered: 1-cycle latency from any mode, duty or write change. Mode changes take effect at any cycle, with no resynchronisation of the counters.
- Channels are independent; no cross-channel interaction except the shared counters.

Decomposition:
- Package board_io_pkg: LED mode localparams LED_MODE_DIRECT=2'b00, LED_MODE_PWM=2'b01, LED_MODE_BLINK=2'b10, LED_MODE_OFF=2'b11; clog2 helper function.
- One sub-module, btn_debounce: sync + counter + level + edge pulses for a single channel, instantiated NUM_BTN times via generate.
- LED logic stays inline, using a generate loop over NUM_LED.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, PWM_BITS=4, BLINK_LOG2=3, BTN_ACTIVE_LOW=1.
1. Reset release with btn_raw=2'b11 held -> all outputs 0 for 50 cycles; no btn_press pulse.
2. btn_raw[0] 1->0 held -> btn_level[0]=1 exactly 6 cycles after the first sampling edge; btn_press[0] high 1 cycle; btn_event[0]=1 and stays set.
3. btn_raw[0] pulses low for 3 cycles then returns high, repeated 5 times -> btn_level[0] stays 0; no pulses.
4. btn_event[0]=1, then btn_event_clr[0]=1 in the same cycle as a new btn_press[0] -> btn_event[0] remains 1. A later clr alone clears it to 0 the next cycle.
5. LED0 mode PWM, led_write=1, duty=4 -> led_out[0] high 4 of every 16 cycles. duty=0 -> never high. duty=15 -> high 15/16.
6. LED1 mode BLINK, led_write=1 -> led_out[1] toggles every 4 cycles. Switch to OFF -> 0 on the next cycle. Assert io_asyncResetN=0 mid-operation -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared definitions for the board I/O conditioner: LED mode encodings and
// an elaboration-time ceil(log2) helper used to size the debounce counters.
package board_io_pkg;

    localparam logic [1:0] LED_MODE_DIRECT = 2'b00;
    localparam logic [1:0] LED_MODE_PWM    = 2'b01;
    localparam logic [1:0] LED_MODE_BLINK  = 2'b10;
    localparam logic [1:0] LED_MODE_OFF    = 2'b11;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/board_io_ctrl_btn_debounce.sv
// Single-button conditioner: 2-FF synchroniser, hold-time debounce counter,
// debounced level and one-cycle press/release pulses.
module btn_debounce
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic io_mainClk,
    input  logic io_asyncResetN,
    input  logic i_btn_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int             CNT_W    = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic           IDLE_RAW = BTN_ACTIVE_LOW;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic [CNT_W-1:0] r_cnt;
    logic             w_pressed;
    logic             w_differs;
    logic             w_accept;

    assign w_pressed = r_sync2 ^ IDLE_RAW;
    assign w_differs = (w_pressed != r_level);
    assign w_accept  = w_differs && (r_cnt == CNT_LAST);

    // Synchroniser idles at the released pad level so reset release is quiet.
    always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
        if (!io_asyncResetN) begin
            r_sync1 <= IDLE_RAW;
            r_sync2 <= IDLE_RAW;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce counter, accepted level and edge pulses.
    always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
        if (!io_asyncResetN) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_accept & w_pressed;
            r_release <= w_accept & ~w_pressed;
            if (w_accept) begin
                r_level <= w_pressed;
                r_cnt   <= '0;
            end else if (w_differs) begin
                r_cnt <= r_cnt + CNT_W'(1'b1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O conditioner: debounced buttons with sticky press flags, and LEDs
// driven per channel in direct, PWM, blink or off mode from shared counters.
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int NUM_BTN         = 2,
    parameter int NUM_LED         = 2,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int PWM_BITS        = 8,
    parameter int BLINK_LOG2      = 22
) (
    input  logic                        io_mainClk,
    input  logic                        io_asyncResetN,
    input  logic [NUM_BTN-1:0]          btn_raw,
    output logic [NUM_BTN-1:0]          btn_level,
    output logic [NUM_BTN-1:0]          btn_press,
    output logic [NUM_BTN-1:0]          btn_release,
    output logic [NUM_BTN-1:0]          btn_event,
    input  logic [NUM_BTN-1:0]          btn_event_clr,
    input  logic [NUM_LED-1:0]          led_write,
    input  logic [2*NUM_LED-1:0]        led_mode,
    input  logic [PWM_BITS*NUM_LED-1:0] led_duty,
    output logic [NUM_LED-1:0]          led_out
);

    logic [NUM_BTN-1:0]    r_btn_event;
    logic [PWM_BITS-1:0]   r_pwm_cnt;
    logic [BLINK_LOG2-1:0] r_blink_cnt;
    logic [NUM_LED-1:0]    r_led_out;
    logic [NUM_LED-1:0]    w_led_next;

    function automatic logic led_next(input logic [1:0] mode, input logic write,
                                      input logic pwm_on, input logic blink_on);
        logic on;
        case (mode)
            LED_MODE_DIRECT: on = write;
            LED_MODE_PWM:    on = write & pwm_on;
            LED_MODE_BLINK:  on = write & blink_on;
            LED_MODE_OFF:    on = 1'b0;
            default:         on = 1'b0;
        endcase
        return on;
    endfunction

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
        ) u_debounce (
            .io_mainClk    (io_mainClk),
            .io_asyncResetN(io_asyncResetN),
            .i_btn_raw     (btn_raw[g]),
            .o_level       (btn_level[g]),
            .o_press       (btn_press[g]),
            .o_release     (btn_release[g])
        );
    end

    // Sticky flag follows the registered press pulse, so a clear landing in
    // the pulse cycle loses to the set.
    always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
        if (!io_asyncResetN) begin
            r_btn_event <= '0;
        end else begin
            r_btn_event <= (r_btn_event & ~btn_event_clr) | btn_press;
        end
    end

    // Free-running shared PWM and blink timebases.
    always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
        if (!io_asyncResetN) begin
            r_pwm_cnt   <= '0;
            r_blink_cnt <= '0;
        end else begin
            r_pwm_cnt   <= r_pwm_cnt + PWM_BITS'(1'b1);
            r_blink_cnt <= r_blink_cnt + BLINK_LOG2'(1'b1);
        end
    end

    for (genvar l = 0; l < NUM_LED; l++) begin : g_led
        assign w_led_next[l] = led_next(led_mode[2*l +: 2], led_write[l],
                                        (r_pwm_cnt < led_duty[PWM_BITS*l +: PWM_BITS]),
                                        r_blink_cnt[BLINK_LOG2-1]);
    end

    // LED pad drive register.
    always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
        if (!io_asyncResetN) begin
            r_led_out <= '0;
        end else begin
            r_led_out <= w_led_next;
        end
    end

    assign btn_event = r_btn_event;
    assign led_out   = r_led_out;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl with short debounce/PWM/blink parameters.
module tb_board_io_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] btn_raw;
    logic [1:0] btn_level, btn_press, btn_release, btn_event, btn_event_clr;
    logic [1:0] led_write, led_out;
    logic [3:0] led_mode;
    logic [7:0] led_duty;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    board_io_ctrl #(
        .NUM_BTN(2), .NUM_LED(2), .BTN_ACTIVE_LOW(1'b1),
        .DEBOUNCE_CYCLES(4), .PWM_BITS(4), .BLINK_LOG2(3)
    ) dut (
        .io_mainClk(clk), .io_asyncResetN(rst_n),
        .btn_raw(btn_raw), .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_event(btn_event), .btn_event_clr(btn_event_clr),
        .led_write(led_write), .led_mode(led_mode), .led_duty(led_duty), .led_out(led_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        logic [1:0] seen;
        logic       s [20];
        logic       prev;
        int         cnt;
        int         j;
        int         bad;
        bit         found;

        rst_n = 1'b1; btn_raw = 2'b11; btn_event_clr = 2'b00;
        led_write = 2'b00; led_mode = 4'b1111; led_duty = 8'h00;
        #1 rst_n = 1'b0;

        // 1: reset and quiet release with buttons idle high
        repeat (3) step();
        check("rst_btn_level", btn_level, 2'b00);
        check("rst_btn_event", btn_event, 2'b00);
        check("rst_led_out",   led_out,   2'b00);
        rst_n = 1'b1;
        seen = 2'b00;
        for (int i = 0; i < 50; i++) begin
            step();
            seen = seen | btn_level | btn_press | btn_release | btn_event | led_out;
        end
        check("t1_quiet_after_release", seen, 2'b00);

        // 2: clean press on channel 0, accepted on the 6th sampling edge
        btn_raw = 2'b10;
        repeat (5) step();
        check("t2_level_edge5", btn_level, 2'b00);
        check("t2_press_edge5", btn_press, 2'b00);
        step();
        check("t2_level_edge6",   btn_level,   2'b01);
        check("t2_press_edge6",   btn_press,   2'b01);
        check("t2_release_edge6", btn_release, 2'b00);
        step();
        check("t2_press_one_cycle", btn_press, 2'b00);
        check("t2_event_set",       btn_event, 2'b01);
        repeat (10) step();
        check("t2_level_held", btn_level, 2'b01);
        check("t2_event_held", btn_event, 2'b01);

        // clean release
        btn_raw = 2'b11;
        repeat (5) step();
        check("t2_rel_level_edge5", btn_level, 2'b01);
        step();
        check("t2_rel_level_edge6", btn_level,   2'b00);
        check("t2_rel_pulse",       btn_release, 2'b01);
        check("t2_rel_no_press",    btn_press,   2'b00);
        step();
        check("t2_rel_one_cycle", btn_release, 2'b00);
        check("t2_rel_event_kept", btn_event,  2'b01);

        // 3: repeated 3-cycle glitches never accepted
        seen = 2'b00;
        for (int r = 0; r < 5; r++) begin
            btn_raw = 2'b10;
            repeat (3) begin step(); seen = seen | btn_level | btn_press | btn_release; end
            btn_raw = 2'b11;
            repeat (5) begin step(); seen = seen | btn_level | btn_press | btn_release; end
        end
        check("t3_glitch_rejected", seen, 2'b00);

        // 4: clear coinciding with a fresh press loses; lone clear wins
        btn_raw = 2'b10;
        repeat (5) step();
        step();
        check("t4_press_again", btn_press, 2'b01);
        btn_event_clr = 2'b01;
        step();
        check("t4_set_wins", btn_event, 2'b01);
        btn_event_clr = 2'b00;
        step();
        check("t4_still_set", btn_event, 2'b01);
        btn_event_clr = 2'b01;
        step();
        check("t4_clr_alone", btn_event, 2'b00);
        btn_event_clr = 2'b00;
        step();
        check("t4_stays_clear", btn_event, 2'b00);
        btn_raw = 2'b11;
        repeat (10) step();
        check("t4_released", btn_level, 2'b00);

        // 5: PWM duty sweep on LED0 over one full 16-cycle period each
        led_mode = 4'b1101; led_write = 2'b01;
        seen = 2'b00;
        led_duty = 8'h04; step();
        cnt = 0;
        for (int i = 0; i < 16; i++) begin step(); cnt += int'(led_out[0]); seen |= led_out & 2'b10; end
        check("t5_duty4", cnt, 4);
        led_duty = 8'h00; step();
        cnt = 0;
        for (int i = 0; i < 16; i++) begin step(); cnt += int'(led_out[0]); seen |= led_out & 2'b10; end
        check("t5_duty0", cnt, 0);
        led_duty = 8'h0F; step();
        cnt = 0;
        for (int i = 0; i < 16; i++) begin step(); cnt += int'(led_out[0]); seen |= led_out & 2'b10; end
        check("t5_duty15", cnt, 15);
        check("t5_led1_off", seen, 2'b00);

        // direct mode and one-cycle output latency
        led_mode = 4'b1100;
        step();
        check("t5_direct_on", led_out, 2'b01);
        led_write = 2'b00;
        #1;
        check("t5_latency_hold", led_out, 2'b01);
        step();
        check("t5_direct_off", led_out, 2'b00);

        // 6: blink on LED1 toggles every 4 cycles
        led_mode = 4'b1011; led_write = 2'b10;
        step();
        for (int i = 0; i < 20; i++) begin step(); s[i] = led_out[1]; end
        j = 0;
        for (int k = 1; k < 5; k++) if (j == 0 && s[k] != s[k-1]) j = k;
        check("t6_first_toggle_found", (j != 0), 1);
        bad = 0;
        for (int m = 0; m < 12; m++) if (s[j+m] !== (s[j] ^ ((m / 4) % 2 == 1))) bad++;
        check("t6_blink_period", bad, 0);

        // switch to OFF right after a rise, when blink would stay high
        prev = led_out[1];
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (!found) begin
                step();
                if (!prev && led_out[1]) found = 1'b1;
                else prev = led_out[1];
            end
        end
        check("t6_rise_found", found, 1);
        led_mode = 4'b1111;
        step();
        check("t6_off_next_cycle", led_out, 2'b00);

        // asynchronous reset mid-operation
        led_mode = 4'b0000; led_write = 2'b11; btn_raw = 2'b10;
        repeat (8) step();
        check("t6_pre_rst_led",   led_out,   2'b11);
        check("t6_pre_rst_level", btn_level, 2'b01);
        check("t6_pre_rst_event", btn_event, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_rst_led",   led_out,   2'b00);
        check("t6_async_rst_level", btn_level, 2'b00);
        check("t6_async_rst_event", btn_event, 2'b00);
        check("t6_async_rst_pulse", btn_press | btn_release, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
